abus_arbiter: RTL

- Round-robin arbiter and multiplexer that shares one abus slave segment between up to 8 abus masters.
- Samples each master's request, id and command strobes, and issues exactly one mgrant.
- Muxes the granted master's address, data, strb and keep onto the slave side, and routes ack back to that master; rdata is broadcast to all masters.
- Includes a watchdog that completes a stalled transfer with a synthetic ack, so that no master can hang the bus.

---
 rtl/abus_arbiter_pkg.sv | 19 +
 rtl/abus_rr_pick.sv | 31 +++
 rtl/abus_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/abus_arbiter_pkg.sv
// Shared definitions for the abus round-robin arbiter: FSM encoding and
// width helpers used by the top and the round-robin picker.
package abus_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } arb_state_t;

  function automatic int strb_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/abus_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping
// modulo NB_MASTERS; valid is low when nobody requests.
module abus_rr_pick
  import abus_arbiter_pkg::*;
#(
  parameter int NB_MASTERS = 4,
  localparam int IW = idx_width(NB_MASTERS)
) (
  input  logic [NB_MASTERS-1:0] req,
  input  logic [IW-1:0]         ptr,
  output logic [IW-1:0]         winner,
  output logic                  valid
);

  logic [IW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    // Scan farthest-first so the nearest requester after ptr overwrites the rest.
    for (int k = NB_MASTERS; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % NB_MASTERS);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/abus_arbiter.sv
// Round-robin arbiter/mux sharing one abus slave between NB_MASTERS masters,
// with a watchdog that completes stalled transfers with a synthetic ack.
module abus_arbiter
  import abus_arbiter_pkg::*;
#(
  parameter int NB_MASTERS = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                                         abus_clk,
  input  logic                                         abus_rstb,
  input  logic [NB_MASTERS-1:0]                        m_mreq,
  input  logic [3*NB_MASTERS-1:0]                      m_mid,
  input  logic [NB_MASTERS-1:0]                        m_mwrite,
  input  logic [NB_MASTERS-1:0]                        m_mread,
  input  logic [NB_MASTERS-1:0]                        m_mabort,
  input  logic [NB_MASTERS*strb_width(DATA_WIDTH)-1:0] m_mstrb,
  input  logic [NB_MASTERS*strb_width(DATA_WIDTH)-1:0] m_mkeep,
  input  logic [NB_MASTERS*DATA_WIDTH-1:0]             m_mwdata,
  input  logic [NB_MASTERS*ADDR_WIDTH-1:0]             m_maddress,
  output logic [NB_MASTERS-1:0]                        m_mgrant,
  output logic [NB_MASTERS-1:0]                        m_mack,
  output logic [DATA_WIDTH-1:0]                        m_mrdata,
  output logic                                         s_req,
  output logic                                         s_write,
  output logic                                         s_read,
  output logic                                         s_abort,
  output logic [2:0]                                   s_mid,
  output logic [strb_width(DATA_WIDTH)-1:0]            s_strb,
  output logic [strb_width(DATA_WIDTH)-1:0]            s_keep,
  output logic [DATA_WIDTH-1:0]                        s_wdata,
  output logic [ADDR_WIDTH-1:0]                        s_address,
  input  logic                                         s_ack,
  input  logic [DATA_WIDTH-1:0]                        s_rdata,
  output logic                                         timeout_err,
  output logic                                         busy,
  output logic [1:0]                                   dbg_state
);

  localparam int SW = strb_width(DATA_WIDTH);
  localparam int IW = idx_width(NB_MASTERS);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Handshake: a master holds mreq until it sees mack on a rising edge while
  // granted; mack is that edge's completion, and dropping mreq early withdraws.

  arb_state_t    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic          granted;
  logic          req_g;
  logic          wd_expire;

  abus_rr_pick #(.NB_MASTERS(NB_MASTERS)) u_pick (
    .req    (m_mreq),
    .ptr    (ptr_q),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  assign granted   = (state_q == S_GRANT);
  assign req_g     = m_mreq[gidx_q];
  assign wd_expire = (TIMEOUT != 0) && granted && req_g && !s_ack &&
                     (wd_cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge abus_clk or negedge abus_rstb) begin
    if (!abus_rstb) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      gidx_q   <= '0;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    wd_cnt_d = wd_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d  = S_GRANT;
          gidx_d   = pick_idx;
          wd_cnt_d = '0;
        end
      end
      S_GRANT: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        if (!req_g) begin
          state_d = S_IDLE;
          ptr_d   = gidx_q;
        end else if (s_ack || wd_expire) begin
          state_d = S_RELEASE;
          ptr_d   = gidx_q;
        end
      end
      // One dead cycle lets the finishing master lower mreq before re-arbitration.
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_mgrant  = '0;
    m_mack    = '0;
    s_req     = 1'b0;
    s_write   = 1'b0;
    s_read    = 1'b0;
    s_abort   = 1'b0;
    s_mid     = '0;
    s_strb    = '0;
    s_keep    = '0;
    s_wdata   = '0;
    s_address = '0;
    if (granted) begin
      m_mgrant[gidx_q] = 1'b1;
      m_mack[gidx_q]   = s_ack || wd_expire;
      s_req     = req_g;
      s_write   = m_mwrite[gidx_q];
      s_read    = m_mread[gidx_q];
      s_abort   = m_mabort[gidx_q];
      s_mid     = m_mid[int'(gidx_q)*3 +: 3];
      s_strb    = m_mstrb[int'(gidx_q)*SW +: SW];
      s_keep    = m_mkeep[int'(gidx_q)*SW +: SW];
      s_wdata   = m_mwdata[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
      s_address = m_maddress[int'(gidx_q)*ADDR_WIDTH +: ADDR_WIDTH];
    end
    timeout_err = wd_expire;
    busy        = (state_q != S_IDLE);
    dbg_state   = state_q;
    m_mrdata    = s_rdata;
  end

endmodule
